// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin cache-line memory arbiter with timeout abort
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cs,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              d_cs,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              i_ack,
    output logic              d_ack,
    output logic [LINE_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       last_d;   // 1: D side was served last, so I wins the next tie
    logic       owner_d;  // 1: current transaction belongs to the D side
    logic       grant_i;
    logic       grant_d;
    logic       done;
    logic       timeout;

    // Grant decode and BUSY termination conditions; mem_ack beats the timeout
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        if (state == IDLE) begin
            grant_i = i_cs && (!d_cs || last_d);
            grant_d = d_cs && (!i_cs || !last_d);
        end
        if (state == BUSY) begin
            done    = mem_ack;
            timeout = !mem_ack && (wait_cnt == TMO);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = BUSY;
            BUSY:    if (done || timeout)    state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered memory request, completion pulses, read data and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= 8'd0;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            if (grant_i || grant_d) begin
                owner_d   <= grant_d;
                mem_cs    <= 1'b1;
                mem_we    <= grant_d ? d_we    : i_we;
                mem_addr  <= grant_d ? d_addr  : i_addr;
                mem_wdata <= grant_d ? d_wdata : i_wdata;
                wait_cnt  <= 8'd0;
            end else if (done || timeout) begin
                mem_cs <= 1'b0;
                i_ack  <= !owner_d;
                d_ack  <= owner_d;
                err    <= timeout;
                last_d <= owner_d;
                if (done && !mem_we) begin
                    rdata <= mem_rdata;
                end
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_cs, i_we, d_cs, d_we;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_ack, d_ack, err;
    logic [LINE_W-1:0] rdata;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_cs(d_cs), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_ack(i_ack), .d_ack(d_ack), .rdata(rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ics, iwe, dcs, dwe, ack;
        logic [7:0] rd;
        logic       ecs, eiack, edack, eerr, ewe;
        logic [31:0] eaddr;
        logic [7:0] erd;
    } vec_t;

    vec_t tbl[16];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkl(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_cnt;
        logic seen;

        rst = 1'b0;
        i_cs = 0; i_we = 0; d_cs = 0; d_we = 0; mem_ack = 0;
        i_addr = 32'h200; d_addr = 32'h100;
        i_wdata = {8{16'h1234}}; d_wdata = {8{16'h5678}};
        mem_rdata = '0;

        // ics iwe dcs dwe ack rd    | cs iack dack err we addr    rdata
        tbl[0]  = '{1,0,1,0,0,8'hEE, 1,0,0,0,0,32'h200,8'h00};
        tbl[1]  = '{1,0,1,0,1,8'h11, 0,1,0,0,0,32'h000,8'h11};
        tbl[2]  = '{1,0,1,0,0,8'hEE, 0,0,0,0,0,32'h000,8'h11};
        tbl[3]  = '{1,0,1,0,0,8'hEE, 1,0,0,0,0,32'h100,8'h11};
        tbl[4]  = '{1,0,1,0,1,8'h22, 0,0,1,0,0,32'h000,8'h22};
        tbl[5]  = '{1,0,1,0,0,8'hEE, 0,0,0,0,0,32'h000,8'h22};
        tbl[6]  = '{1,0,1,0,0,8'hEE, 1,0,0,0,0,32'h200,8'h22};
        tbl[7]  = '{0,0,0,0,1,8'h33, 0,1,0,0,0,32'h000,8'h33};
        tbl[8]  = '{0,0,0,0,0,8'hEE, 0,0,0,0,0,32'h000,8'h33};
        tbl[9]  = '{0,0,0,0,1,8'h77, 0,0,0,0,0,32'h000,8'h33};
        tbl[10] = '{0,0,1,0,0,8'hEE, 1,0,0,0,0,32'h100,8'h33};
        tbl[11] = '{0,0,0,0,0,8'hEE, 1,0,0,0,0,32'h100,8'h33};
        tbl[12] = '{0,0,0,0,0,8'hEE, 1,0,0,0,0,32'h100,8'h33};
        tbl[13] = '{0,0,0,0,1,8'hA5, 0,0,1,0,0,32'h000,8'hA5};
        tbl[14] = '{0,0,0,0,0,8'hEE, 0,0,0,0,0,32'h000,8'hA5};
        tbl[15] = '{0,0,0,0,0,8'hEE, 0,0,0,0,0,32'h000,8'hA5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst mem_cs", mem_cs, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chka("rst mem_addr", mem_addr, 32'h0);
        chkl("rst mem_wdata", mem_wdata, '0);
        chkl("rst rdata", rdata, '0);
        chk1("rst i_ack", i_ack, 1'b0);
        chk1("rst d_ack", d_ack, 1'b0);
        chk1("rst err", err, 1'b0);
        #3 rst = 1'b1;
        tick();

        // Ties after reset, round-robin, ignored ack in IDLE, single read
        for (int i = 0; i < 16; i++) begin
            i_cs = tbl[i].ics; i_we = tbl[i].iwe;
            d_cs = tbl[i].dcs; d_we = tbl[i].dwe;
            mem_ack = tbl[i].ack; mem_rdata = {16{tbl[i].rd}};
            tick();
            chk1($sformatf("row%0d mem_cs", i), mem_cs, tbl[i].ecs);
            chk1($sformatf("row%0d i_ack", i), i_ack, tbl[i].eiack);
            chk1($sformatf("row%0d d_ack", i), d_ack, tbl[i].edack);
            chk1($sformatf("row%0d err", i), err, tbl[i].eerr);
            chkl($sformatf("row%0d rdata", i), rdata, {16{tbl[i].erd}});
            if (tbl[i].ecs) begin
                chka($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].eaddr);
                chk1($sformatf("row%0d mem_we", i), mem_we, tbl[i].ewe);
            end
        end
        i_cs = 0; d_cs = 0; mem_ack = 0; mem_rdata = {16{8'hEE}};

        // Timeout abort with TIMEOUT=4: mem_cs high for 5 cycles, then err+d_ack
        d_cs = 1; d_we = 0;
        hi_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            d_cs = 0;
            if (mem_cs) hi_cnt++;
            if (err) begin
                seen = 1'b1;
                chk1("tmo d_ack with err", d_ack, 1'b1);
                chk1("tmo i_ack with err", i_ack, 1'b0);
                chk1("tmo mem_cs at err", mem_cs, 1'b0);
            end
        end
        chk1("tmo err seen", seen, 1'b1);
        chka("tmo mem_cs cycles", 32'(hi_cnt), 32'd5);
        chkl("tmo rdata held", rdata, {16{8'hA5}});
        tick();
        chk1("tmo err one cycle", err, 1'b0);
        chk1("tmo d_ack one cycle", d_ack, 1'b0);
        tick();
        chk1("tmo back idle", mem_cs, 1'b0);

        // Input churn, and mem_ack coinciding with the timeout cycle
        d_cs = 1; d_addr = 32'h100;
        tick();
        chka("churn grant addr", mem_addr, 32'h100);
        d_cs = 0; d_addr = 32'h999; d_wdata = '1;
        repeat (4) tick();
        chk1("churn mem_cs held", mem_cs, 1'b1);
        chka("churn mem_addr held", mem_addr, 32'h100);
        chkl("churn mem_wdata held", mem_wdata, {8{16'h5678}});
        mem_ack = 1; mem_rdata = {16{8'h5A}};
        tick();
        chk1("ackwin d_ack", d_ack, 1'b1);
        chk1("ackwin err", err, 1'b0);
        chkl("ackwin rdata", rdata, {16{8'h5A}});
        mem_ack = 0;
        tick();

        // Write-back from I side: data held through BUSY, rdata untouched
        i_cs = 1; i_we = 1; i_wdata = {8{16'h1234}};
        tick();
        chk1("wb mem_cs", mem_cs, 1'b1);
        chk1("wb mem_we", mem_we, 1'b1);
        chkl("wb mem_wdata", mem_wdata, {8{16'h1234}});
        i_we = 0; i_wdata = '0;
        tick();
        chk1("wb mem_we held", mem_we, 1'b1);
        chkl("wb mem_wdata held", mem_wdata, {8{16'h1234}});
        mem_ack = 1; mem_rdata = {16{8'hC3}};
        tick();
        chk1("wb i_ack", i_ack, 1'b1);
        chk1("wb d_ack", d_ack, 1'b0);
        chkl("wb rdata held", rdata, {16{8'h5A}});
        mem_ack = 0; i_cs = 0;
        tick();

        // Reset mid-BUSY: immediate drop, no pulses, I wins first tie after
        d_cs = 1; d_we = 0; d_addr = 32'h100;
        tick();
        chk1("rstb mem_cs before", mem_cs, 1'b1);
        d_cs = 0;
        #3 rst = 1'b0;
        #1;
        chk1("rstb mem_cs async", mem_cs, 1'b0);
        tick();
        rst = 1'b1;
        mem_ack = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1($sformatf("rstb quiet%0d", k), i_ack | d_ack | err | mem_cs, 1'b0);
        end
        mem_ack = 0;
        i_cs = 1; d_cs = 1; i_addr = 32'h200;
        tick();
        chka("rstb first tie addr", mem_addr, 32'h200);
        i_cs = 0; d_cs = 0; mem_ack = 1;
        tick();
        chk1("rstb first tie i_ack", i_ack, 1'b1);
        mem_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
